// File: rtl/project_pkg.sv
// Shared constants, port widths and FSM state encoding for the grid renderer.
package project_pkg;

  localparam int unsigned DEF_GRID_W    = 40;
  localparam int unsigned DEF_GRID_H    = 30;
  localparam int unsigned DEF_CELL_SIZE = 4;

  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned OFS_W    = 7;

  localparam logic [COLOUR_W-1:0] DEF_ALIVE_COLOUR = 3'b010;
  localparam logic [COLOUR_W-1:0] DEF_DEAD_COLOUR  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PAINT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/grid_render_if.sv
// Request, cell-memory and VGA-adapter signals of the grid renderer.
interface grid_render_if;
  import project_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   cell_addr;
  logic                cell_data;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport slave (
    input  start, cell_data,
    output cell_addr, x, y, colour, plot, busy, done
  );

  modport master (
    output start, cell_data,
    input  cell_addr, x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/grid_render_cell_scan_counter.sv
// Pixel-offset scanner inside one cell: px fastest, py steps when px wraps.
module cell_scan_counter
  import project_pkg::*;
#(
  parameter int unsigned CELL_SIZE = DEF_CELL_SIZE
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [OFS_W-1:0] o_px_nxt,
  output logic [OFS_W-1:0] o_py_nxt,
  output logic             o_carry
);

  logic [OFS_W-1:0] r_px;
  logic [OFS_W-1:0] r_py;
  logic             w_px_wrap;
  logic             w_py_wrap;

  assign w_px_wrap = (r_px == OFS_W'(CELL_SIZE - 1));
  assign w_py_wrap = (r_py == OFS_W'(CELL_SIZE - 1));

  // Terminal count depends on state only, so it can steer the FSM without a loop.
  assign o_carry = w_px_wrap && w_py_wrap;

  always_comb begin
    o_px_nxt = r_px;
    o_py_nxt = r_py;
    if (i_clr) begin
      o_px_nxt = '0;
      o_py_nxt = '0;
    end else if (i_en) begin
      o_px_nxt = w_px_wrap ? '0 : r_px + OFS_W'(1);
      if (w_px_wrap) begin
        o_py_nxt = w_py_wrap ? '0 : r_py + OFS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_px <= '0;
      r_py <= '0;
    end else begin
      r_px <= o_px_nxt;
      r_py <= o_py_nxt;
    end
  end

endmodule

// File: rtl/grid_render.sv
// Walks the cell grid, fetches each cell state and paints it as a
// CELL_SIZE x CELL_SIZE block of VGA pixels.
module grid_render
  import project_pkg::*;
#(
  parameter int unsigned         GRID_W       = DEF_GRID_W,
  parameter int unsigned         GRID_H       = DEF_GRID_H,
  parameter int unsigned         CELL_SIZE    = DEF_CELL_SIZE,
  parameter logic [COLOUR_W-1:0] ALIVE_COLOUR = DEF_ALIVE_COLOUR,
  parameter logic [COLOUR_W-1:0] DEAD_COLOUR  = DEF_DEAD_COLOUR
)(
  input logic           clk,
  input logic           reset,
  grid_render_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [X_W-1:0]      r_col;
  logic [Y_W-1:0]      r_row;
  logic [ADDR_W-1:0]   r_cell_addr;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;

  logic                w_busy;
  logic                w_done;
  logic                w_cnt_clr;
  logic                w_cnt_en;
  logic                w_carry;
  logic                w_last_col;
  logic                w_last_cell;
  logic [X_W-1:0]      w_col_adv;
  logic [Y_W-1:0]      w_row_adv;
  logic [OFS_W-1:0]    w_px_nxt;
  logic [OFS_W-1:0]    w_py_nxt;
  logic [15:0]         w_x_full;
  logic [15:0]         w_y_full;
  logic [15:0]         w_addr_full;

  cell_scan_counter #(
    .CELL_SIZE (CELL_SIZE)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_px_nxt (w_px_nxt),
    .o_py_nxt (w_py_nxt),
    .o_carry  (w_carry)
  );

  assign w_last_col  = (r_col == X_W'(GRID_W - 1));
  assign w_last_cell = w_last_col && (r_row == Y_W'(GRID_H - 1));
  assign w_col_adv   = w_last_col ? '0 : r_col + X_W'(1);
  assign w_row_adv   = w_last_col ? r_row + Y_W'(1) : r_row;

  // Coordinates use the upcoming pixel offset so x/y land in the same cycle as plot.
  assign w_x_full    = 16'(r_col) * 16'(CELL_SIZE) + 16'(w_px_nxt);
  assign w_y_full    = 16'(r_row) * 16'(CELL_SIZE) + 16'(w_py_nxt);
  assign w_addr_full = 16'(w_row_adv) * 16'(GRID_W) + 16'(w_col_adv);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy      = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_PAINT;
      end
      ST_PAINT: begin
        w_busy   = 1'b1;
        w_cnt_en = 1'b1;
        if (w_carry) w_state_nxt = w_last_cell ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_cell_addr <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_colour    <= DEAD_COLOUR;
      r_plot      <= 1'b0;
    end else begin
      r_plot <= (w_state_nxt == ST_PAINT);
      if (w_state_nxt == ST_PAINT) begin
        r_x <= X_W'(w_x_full);
        r_y <= Y_W'(w_y_full);
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_col       <= '0;
            r_row       <= '0;
            r_cell_addr <= '0;
          end
        end
        ST_WAIT: begin
          r_colour <= bus.cell_data ? ALIVE_COLOUR : DEAD_COLOUR;
        end
        ST_PAINT: begin
          if (w_carry && !w_last_cell) begin
            r_col       <= w_col_adv;
            r_row       <= w_row_adv;
            r_cell_addr <= ADDR_W'(w_addr_full);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cell_addr = r_cell_addr;
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.colour    = r_colour;
  assign bus.plot      = r_plot;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_grid_render.sv
// Bench for grid_render: default-size frames against a pixel scoreboard,
// plus reset, ignored-start and small-grid sequences.
module tb_grid_render;
  import project_pkg::*;

  localparam int unsigned W     = 40;
  localparam int unsigned H     = 30;
  localparam int unsigned CS    = 4;
  localparam int unsigned NCELL = W * H;
  localparam logic [2:0]  A_ALIVE = 3'b010;
  localparam logic [2:0]  A_DEAD  = 3'b000;

  localparam int unsigned BW  = 2;
  localparam int unsigned BH  = 2;
  localparam int unsigned BCS = 2;
  localparam logic [2:0]  B_ALIVE = 3'b101;
  localparam logic [2:0]  B_DEAD  = 3'b001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grid_render_if bus_a ();
  grid_render_if bus_b ();

  grid_render dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  grid_render #(
    .GRID_W       (BW),
    .GRID_H       (BH),
    .CELL_SIZE    (BCS),
    .ALIVE_COLOUR (B_ALIVE),
    .DEAD_COLOUR  (B_DEAD)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Synchronous 1-read-latency cell memories
  logic mem_a [NCELL];
  logic mem_b [4];
  always @(posedge clk) begin
    bus_a.cell_data <= mem_a[int'(bus_a.cell_addr) % NCELL];
    bus_b.cell_data <= mem_b[bus_b.cell_addr[1:0]];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  // ---------------- scoreboard for dut_a ----------------
  pix_t        exp_q[$];
  int unsigned a_plots, a_alive, a_pix_err, a_range_err, a_done_n, a_done_cyc, a_start_cyc;

  always @(negedge clk) begin
    pix_t got;
    pix_t e;
    if (bus_a.plot) begin
      got.x = bus_a.x;
      got.y = bus_a.y;
      got.c = bus_a.colour;
      a_plots++;
      if (got.c == A_ALIVE) a_alive++;
      if (got.x > 8'd159 || got.y > 7'd119) a_range_err++;
      if (exp_q.size() == 0) begin
        if (a_pix_err == 0) $display("note: dut_a plotted x=%0d y=%0d with nothing expected", got.x, got.y);
        a_pix_err++;
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          if (a_pix_err == 0)
            $display("note: first dut_a pixel diff at plot %0d: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                     a_plots, got.x, got.y, got.c, e.x, e.y, e.c);
          a_pix_err++;
        end
      end
    end
    if (bus_a.done) begin
      a_done_n++;
      a_done_cyc = cyc - a_start_cyc;
    end
  end

  task automatic fill_a(input int unsigned mode);
    for (int unsigned i = 0; i < NCELL; i++)
      mem_a[i] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mode == 1) begin
      mem_a[0]       = 1'b1;
      mem_a[NCELL-1] = 1'b1;
    end
  endtask

  task automatic push_a();
    pix_t e;
    exp_q.delete();
    for (int unsigned r = 0; r < H; r++)
      for (int unsigned c = 0; c < W; c++)
        for (int unsigned py = 0; py < CS; py++)
          for (int unsigned px = 0; px < CS; px++) begin
            e.x = 8'(c * CS + px);
            e.y = 7'(r * CS + py);
            e.c = mem_a[r * W + c] ? A_ALIVE : A_DEAD;
            exp_q.push_back(e);
          end
  endtask

  // Drives start for one cycle; returns at the negedge of frame cycle 1.
  task automatic start_a();
    @(negedge clk);
    push_a();
    a_plots = 0; a_alive = 0; a_pix_err = 0; a_range_err = 0;
    a_done_n = 0; a_done_cyc = 0;
    a_start_cyc = cyc;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_a(input int unsigned restart_at, input int unsigned limit);
    while (a_done_n == 0 && (cyc - a_start_cyc) < limit) begin
      @(negedge clk);
      bus_a.start = (restart_at != 0) && ((cyc - a_start_cyc) == restart_at);
    end
    bus_a.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- small-grid sequence for dut_b ----------------
  pix_t        exp_qb[$];
  int unsigned b_addr_log[$];

  // Called at the negedge where start is already high (frame cycle 0).
  task automatic frame_b(input string tag);
    pix_t e;
    pix_t got;
    logic prev_fw;
    int unsigned plots;
    int unsigned perr;
    int          done_k;
    exp_qb.delete();
    b_addr_log.delete();
    for (int unsigned r = 0; r < BH; r++)
      for (int unsigned c = 0; c < BW; c++)
        for (int unsigned py = 0; py < BCS; py++)
          for (int unsigned px = 0; px < BCS; px++) begin
            e.x = 8'(c * BCS + px);
            e.y = 7'(r * BCS + py);
            e.c = mem_b[r * BW + c] ? B_ALIVE : B_DEAD;
            exp_qb.push_back(e);
          end
    prev_fw = 1'b0;
    plots   = 0;
    perr    = 0;
    done_k  = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_b.start = 1'b0;
        check({tag, "_busy_after_accept"}, bus_b.busy, 1);
      end
      if (bus_b.busy && !bus_b.plot && !prev_fw) b_addr_log.push_back(int'(bus_b.cell_addr));
      prev_fw = bus_b.busy && !bus_b.plot;
      if (bus_b.plot) begin
        plots++;
        got.x = bus_b.x;
        got.y = bus_b.y;
        got.c = bus_b.colour;
        if (exp_qb.size() == 0) perr++;
        else begin
          e = exp_qb.pop_front();
          if (got != e) perr++;
        end
      end
      if (bus_b.done) begin
        done_k = k;
        break;
      end
    end
    check({tag, "_done_cycle"}, done_k, 25);
    check({tag, "_plots"}, plots, 16);
    check({tag, "_pixel_errors"}, perr, 0);
    check({tag, "_pixels_left"}, exp_qb.size(), 0);
    check({tag, "_addr_count"}, b_addr_log.size(), 4);
    for (int unsigned i = 0; i < b_addr_log.size(); i++)
      check({tag, "_addr_seq"}, b_addr_log[i], i);
  endtask

  // ---------------- vector table for full-size frames ----------------
  typedef struct {
    string       name;
    int unsigned mode;        // 0 all dead, 1 cells (0,0)+(39,29), 2 random
    int unsigned restart_at;  // frame cycle of a spurious start, 0 = none
    int unsigned exp_plots;
    int unsigned exp_done;
    int          exp_alive;   // -1: derive from the random pattern
  } vec_t;

  vec_t        vecs[3];
  int          exp_alive;
  int unsigned snap_plots;

  initial begin
    vecs[0] = '{name: "all_dead", mode: 0, restart_at: 0,   exp_plots: 19200, exp_done: 21601, exp_alive: 0};
    vecs[1] = '{name: "corners",  mode: 1, restart_at: 500, exp_plots: 19200, exp_done: 21601, exp_alive: 32};
    vecs[2] = '{name: "random",   mode: 2, restart_at: 0,   exp_plots: 19200, exp_done: 21601, exp_alive: -1};
    mem_b[0] = 1'b0; mem_b[1] = 1'b1; mem_b[2] = 1'b1; mem_b[3] = 1'b0;
    fill_a(0);

    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_plot",   bus_a.plot,      0);
    check("rst_a_busy",   bus_a.busy,      0);
    check("rst_a_done",   bus_a.done,      0);
    check("rst_a_x",      bus_a.x,         0);
    check("rst_a_y",      bus_a.y,         0);
    check("rst_a_colour", bus_a.colour,    A_DEAD);
    check("rst_a_addr",   bus_a.cell_addr, 0);
    check("rst_b_colour", bus_b.colour,    B_DEAD);
    check("rst_b_busy",   bus_b.busy,      0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int unsigned i = 0; i < 3; i++) begin
      fill_a(vecs[i].mode);
      exp_alive = vecs[i].exp_alive;
      if (exp_alive < 0) begin
        exp_alive = 0;
        for (int unsigned j = 0; j < NCELL; j++) if (mem_a[j]) exp_alive += CS * CS;
      end
      start_a();
      wait_a(vecs[i].restart_at, vecs[i].exp_done + 50);
      check({vecs[i].name, "_done_pulses"}, a_done_n,    1);
      check({vecs[i].name, "_done_cycle"},  a_done_cyc,  vecs[i].exp_done);
      check({vecs[i].name, "_plots"},       a_plots,     vecs[i].exp_plots);
      check({vecs[i].name, "_alive_px"},    a_alive,     exp_alive);
      check({vecs[i].name, "_pixel_errs"},  a_pix_err,   0);
      check({vecs[i].name, "_range_errs"},  a_range_err, 0);
      check({vecs[i].name, "_pixels_left"}, exp_q.size(), 0);
      check({vecs[i].name, "_busy_after"},  bus_a.busy,  0);
      check({vecs[i].name, "_plot_after"},  bus_a.plot,  0);
    end

    // Reset at frame cycle 1000 together with start
    fill_a(2);
    start_a();
    while ((cyc - a_start_cyc) < 1000) @(negedge clk);
    reset = 1'b1;
    bus_a.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_a.start = 1'b0;
    check("midrst_plot",   bus_a.plot,      0);
    check("midrst_busy",   bus_a.busy,      0);
    check("midrst_done",   bus_a.done,      0);
    check("midrst_addr",   bus_a.cell_addr, 0);
    check("midrst_x",      bus_a.x,         0);
    check("midrst_colour", bus_a.colour,    A_DEAD);
    snap_plots = a_plots;
    repeat (40) @(negedge clk);
    check("midrst_no_done",  a_done_n, 0);
    check("midrst_no_plots", a_plots,  snap_plots);
    check("midrst_idle",     bus_a.busy, 0);

    start_a();
    check("redraw_first_addr", bus_a.cell_addr, 0);
    check("redraw_busy",       bus_a.busy,      1);
    while ((cyc - a_start_cyc) < 19) @(negedge clk);
    check("redraw_second_addr", bus_a.cell_addr, 1);
    check("redraw_first_plots", a_plots,         16);
    check("redraw_pixel_errs",  a_pix_err,       0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Small grid, then start held across the done cycle
    bus_b.start = 1'b1;
    frame_b("small1");
    bus_b.start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", bus_b.busy, 0);
    check("done_single_pulse",     bus_b.done, 0);
    frame_b("small2");
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
